// File: rtl/glb_dma_pkg.sv
// Shared types and constants for the GLB DMA loader and its drain skid buffer.
package glb_dma_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_IFMAP  = 3'd1,
    LD_FILTER = 3'd2,
    LD_BIAS   = 3'd3,
    COMPUTE   = 3'd4,
    DRAIN     = 3'd5,
    FINISH    = 3'd6
  } dma_state_t;

  typedef enum logic [1:0] {
    RGN_IFMAP  = 2'd0,
    RGN_FILTER = 2'd1,
    RGN_BIAS   = 2'd2,
    RGN_OPSUM  = 2'd3
  } region_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/glb_drain_skid.sv
// Two-entry FIFO that absorbs GLB read latency so the drain stream can run at
// one word per cycle and hold its head word stable under backpressure.
module glb_drain_skid
  import glb_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(SKID_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage and 1-bit pointers (depth is 2, so each pointer simply toggles).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (srst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/glb_dma_loader.sv
// Job sequencer: loads ifmap/filter/bias into the GLB, kicks the processing
// unit, then drains the opsum region out through a skid buffer.
module glb_dma_loader
  import glb_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_ifmap_base,
  input  logic [ADDR_WIDTH-1:0] cfg_filter_base,
  input  logic [ADDR_WIDTH-1:0] cfg_bias_base,
  input  logic [ADDR_WIDTH-1:0] cfg_opsum_base,
  input  logic [LEN_WIDTH-1:0]  cfg_ifmap_len,
  input  logic [LEN_WIDTH-1:0]  cfg_filter_len,
  input  logic [LEN_WIDTH-1:0]  cfg_bias_len,
  input  logic [LEN_WIDTH-1:0]  cfg_opsum_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  glb_sel,
  output logic                  glb_we,
  output logic [ADDR_WIDTH-1:0] glb_waddr,
  output logic [DATA_WIDTH-1:0] glb_wdata,
  output logic                  glb_re,
  output logic [ADDR_WIDTH-1:0] glb_raddr,
  input  logic [DATA_WIDTH-1:0] glb_rdata,
  output logic                  pu_start,
  input  logic                  pu_done
);

  dma_state_t            state;
  dma_state_t            next_state;
  region_t               region;
  logic [ADDR_WIDTH-1:0] base [4];
  logic [LEN_WIDTH-1:0]  len  [4];
  logic [ADDR_WIDTH-1:0] cur_base;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LEN_WIDTH-1:0]  count;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  popped;
  logic [LEN_WIDTH:0]    popped_next;
  logic                  rd_pend;
  logic                  loading;
  logic                  ld_hs;
  logic                  ld_last;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;

  // Region selected by the current phase.
  always_comb begin
    region = RGN_IFMAP;
    case (state)
      LD_IFMAP:  region = RGN_IFMAP;
      LD_FILTER: region = RGN_FILTER;
      LD_BIAS:   region = RGN_BIAS;
      DRAIN:     region = RGN_OPSUM;
      default:   region = RGN_IFMAP;
    endcase
  end

  assign cur_base    = base[region];
  assign cur_len     = len[region];
  assign loading     = state inside {LD_IFMAP, LD_FILTER, LD_BIAS};
  assign s_ready     = loading && (count < cur_len);
  assign ld_hs       = s_valid && s_ready;
  assign ld_last     = (count >= cur_len) || (ld_hs && ((count + LEN_WIDTH'(1)) == cur_len));
  assign m_valid     = !fifo_empty;
  assign pop         = m_valid && m_ready;
  assign popped_next = {1'b0, popped} + {{LEN_WIDTH{1'b0}}, pop};

  // Credit a same-cycle pop so stored + in-flight never exceeds the skid depth
  // yet a free-flowing sink still gets one word every cycle.
  assign glb_re    = (state == DRAIN) && (issued < cur_len) && (!fifo_full || pop) &&
                     ((3'(fifo_count) + 3'(rd_pend)) < (3'(SKID_DEPTH) + 3'(pop)));
  assign glb_raddr = cur_base + ADDR_WIDTH'(issued);

  // Phase sequencing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cfg_start) next_state = LD_IFMAP; else next_state = IDLE;
      LD_IFMAP:  if (ld_last) next_state = LD_FILTER; else next_state = LD_IFMAP;
      LD_FILTER: if (ld_last) next_state = LD_BIAS; else next_state = LD_FILTER;
      LD_BIAS:   if (ld_last) next_state = COMPUTE; else next_state = LD_BIAS;
      COMPUTE:   if (pu_done && !pu_start) next_state = DRAIN; else next_state = COMPUTE;
      DRAIN:     if (popped_next == {1'b0, cur_len}) next_state = FINISH; else next_state = DRAIN;
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State and per-phase word counters; every counter restarts on a phase change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      issued  <= '0;
      popped  <= '0;
      rd_pend <= 1'b0;
    end else begin
      state   <= next_state;
      rd_pend <= glb_re;
      if (next_state != state) begin
        count  <= '0;
        issued <= '0;
        popped <= '0;
      end else begin
        if (ld_hs)  count  <= count + LEN_WIDTH'(1);
        if (glb_re) issued <= issued + LEN_WIDTH'(1);
        if (pop)    popped <= popped + LEN_WIDTH'(1);
      end
    end
  end

  // Job configuration snapshot, taken only when a job is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
      end
    end else if ((state == IDLE) && cfg_start) begin
      base[RGN_IFMAP]  <= cfg_ifmap_base;
      base[RGN_FILTER] <= cfg_filter_base;
      base[RGN_BIAS]   <= cfg_bias_base;
      base[RGN_OPSUM]  <= cfg_opsum_base;
      len[RGN_IFMAP]   <= cfg_ifmap_len;
      len[RGN_FILTER]  <= cfg_filter_len;
      len[RGN_BIAS]    <= cfg_bias_len;
      len[RGN_OPSUM]   <= cfg_opsum_len;
    end
  end

  // Registered status, handoff and GLB write port, aligned with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      glb_sel   <= 1'b0;
      pu_start  <= 1'b0;
      glb_we    <= 1'b0;
      glb_waddr <= '0;
      glb_wdata <= '0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= (next_state == FINISH);
      glb_sel  <= next_state inside {LD_IFMAP, LD_FILTER, LD_BIAS, DRAIN, FINISH};
      pu_start <= (next_state == COMPUTE) && (state != COMPUTE);
      glb_we   <= ld_hs;
      if (ld_hs) begin
        glb_waddr <= cur_base + ADDR_WIDTH'(count);
        glb_wdata <= s_data;
      end
    end
  end

  glb_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .srst      (state != DRAIN),
    .push      (rd_pend),
    .push_data (glb_rdata),
    .pop       (pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_glb_dma_loader.sv
// Randomized self-checking bench: a job-level reference model predicts phase
// timing, GLB write/read traffic and the drained word stream.
module tb_glb_dma_loader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int LW = 20;
  localparam int M_IDLE = 0, M_LOAD = 1, M_COMP = 2, M_DRAIN = 3, M_FIN = 4;

  logic          clk, reset, cfg_start;
  logic [AW-1:0] cfg_ifmap_base, cfg_filter_base, cfg_bias_base, cfg_opsum_base;
  logic [LW-1:0] cfg_ifmap_len, cfg_filter_len, cfg_bias_len, cfg_opsum_len;
  logic          busy, done, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, glb_wdata, glb_rdata;
  logic          glb_sel, glb_we, glb_re, pu_start, pu_done;
  logic [AW-1:0] glb_waddr, glb_raddr;

  int n_cmp = 0;
  int n_bad = 0;

  int            mode, ph, cnt;
  logic          hs_prev, prev_stall;
  logic [DW-1:0] prev_mdata;
  logic [AW-1:0] pbase [4];
  int            plen  [4];
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    dq[$];
  logic [DW-1:0]    words[$];

  glb_dma_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_ifmap_base(cfg_ifmap_base), .cfg_filter_base(cfg_filter_base),
    .cfg_bias_base(cfg_bias_base), .cfg_opsum_base(cfg_opsum_base),
    .cfg_ifmap_len(cfg_ifmap_len), .cfg_filter_len(cfg_filter_len),
    .cfg_bias_len(cfg_bias_len), .cfg_opsum_len(cfg_opsum_len),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .glb_sel(glb_sel), .glb_we(glb_we), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata),
    .glb_re(glb_re), .glb_raddr(glb_raddr), .glb_rdata(glb_rdata),
    .pu_start(pu_start), .pu_done(pu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a + AW'(1));
  endfunction

  // GLB read port: data appears one cycle after the read request.
  always @(posedge clk) if (glb_re === 1'b1) glb_rdata <= mem_word(glb_raddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mode = M_IDLE; ph = 0; cnt = 0; hs_prev = 1'b0; prev_stall = 1'b0;
    wq.delete(); dq.delete(); words.delete();
  endtask

  task automatic scramble_cfg();
    cfg_ifmap_base = AW'($urandom); cfg_filter_base = AW'($urandom);
    cfg_bias_base  = AW'($urandom); cfg_opsum_base  = AW'($urandom);
    cfg_ifmap_len  = LW'($urandom); cfg_filter_len  = LW'($urandom);
    cfg_bias_len   = LW'($urandom); cfg_opsum_len   = LW'($urandom);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_done"},    32'(done),      32'd0);
    check({tag, "_s_ready"}, 32'(s_ready),   32'd0);
    check({tag, "_m_valid"}, 32'(m_valid),   32'd0);
    check({tag, "_glb_sel"}, 32'(glb_sel),   32'd0);
    check({tag, "_glb_we"},  32'(glb_we),    32'd0);
    check({tag, "_glb_re"},  32'(glb_re),    32'd0);
    check({tag, "_pu_start"},32'(pu_start),  32'd0);
    check({tag, "_waddr"},   32'(glb_waddr), 32'd0);
    check({tag, "_m_data"},  32'(m_data),    32'd0);
  endtask

  // One job: rpct < 0 selects the fixed m_ready pattern 1,0,0,1.
  // abort_ph >= 0 asserts reset once that load phase has accepted one word.
  task automatic run_job(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                         input logic [AW-1:0] b2, input logic [AW-1:0] b3,
                         input int l0, input int l1, input int l2, input int l3,
                         input int vpct, input int rpct, input int pdly,
                         input bit seq_data, input int abort_ph);
    int cyc, comp_cyc, issued, popped, first_pop, npop, k;
    bit finished, hs, pop, aborted;
    bit [3:0] pat;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [AW+DW-1:0] e;
    pat = 4'b1001;
    pbase[0] = b0; pbase[1] = b1; pbase[2] = b2; pbase[3] = b3;
    plen[0] = l0; plen[1] = l1; plen[2] = l2; plen[3] = l3;
    k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < plen[r]; i++) begin
        w = seq_data ? DW'(k + 1) : DW'($urandom);
        a = pbase[r] + AW'(i);
        words.push_back(w);
        wq.push_back({a, w});
        k++;
      end
    end
    for (int i = 0; i < l3; i++) dq.push_back(mem_word(b3 + AW'(i)));
    cyc = 0; comp_cyc = 0; issued = 0; popped = 0; first_pop = -1; npop = 0;
    finished = 1'b0; aborted = 1'b0;
    while (cyc < 500 && !finished) begin
      @(negedge clk);
      if (mode == M_LOAD && ph == abort_ph && cnt == 1) begin
        aborted = 1'b1;
        reset = 1'b0;
        #1;
        reset_checks("abort");
        break;
      end
      if (cyc == 0) begin
        cfg_ifmap_base = b0; cfg_filter_base = b1; cfg_bias_base = b2; cfg_opsum_base = b3;
        cfg_ifmap_len = LW'(l0); cfg_filter_len = LW'(l1);
        cfg_bias_len = LW'(l2); cfg_opsum_len = LW'(l3);
        cfg_start = 1'b1;
      end else begin
        scramble_cfg();
        cfg_start = (mode == M_COMP && comp_cyc == 2);
      end
      s_valid = ($urandom_range(99) < vpct);
      s_data  = (words.size() > 0) ? words[0] : DW'($urandom);
      m_ready = (rpct < 0) ? pat[cyc % 4] : ($urandom_range(99) < rpct);
      pu_done = (mode == M_COMP) && (comp_cyc == 0 || comp_cyc == pdly);
      #1;
      check("busy",     32'(busy),     32'(mode != M_IDLE));
      check("done",     32'(done),     32'(mode == M_FIN));
      check("glb_sel",  32'(glb_sel),  32'(mode == M_LOAD || mode == M_DRAIN || mode == M_FIN));
      check("pu_start", 32'(pu_start), 32'(mode == M_COMP && comp_cyc == 0));
      check("s_ready",  32'(s_ready),  32'(mode == M_LOAD && cnt < plen[ph]));
      check("glb_we",   32'(glb_we),   32'(hs_prev));
      if (glb_we === 1'b1) begin
        if (wq.size() == 0) check("extra_write", 32'd1, 32'd0);
        else begin
          e = wq.pop_front();
          check("waddr", 32'(glb_waddr), 32'(e[AW+DW-1:DW]));
          check("wdata", 32'(glb_wdata), 32'(e[DW-1:0]));
        end
      end
      hs = s_valid && (s_ready === 1'b1);
      if (mode != M_DRAIN) begin
        check("idle_re",     32'(glb_re),  32'd0);
        check("idle_mvalid", 32'(m_valid), 32'd0);
      end
      if (glb_re === 1'b1) begin
        check("raddr", 32'(glb_raddr), 32'(b3 + AW'(issued)));
        issued++;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data",  32'(m_data),  32'(prev_mdata));
      end
      pop = (m_valid === 1'b1) && m_ready;
      if (pop) begin
        if (dq.size() == 0) check("extra_pop", 32'd1, 32'd0);
        else check("m_data", 32'(m_data), 32'(dq.pop_front()));
        if (rpct == 100) begin
          if (first_pop < 0) first_pop = cyc;
          check("pop_rate", 32'(cyc), 32'(first_pop + npop));
        end
        npop++;
        popped++;
      end
      if (mode == M_DRAIN) check("inflight", 32'((issued - popped) <= 2), 32'd1);
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_mdata = m_data;
      hs_prev = hs;
      if (hs && words.size() > 0) void'(words.pop_front());
      case (mode)
        M_IDLE: if (cfg_start) begin mode = M_LOAD; ph = 0; cnt = 0; end
        M_LOAD: begin
          if (hs) cnt++;
          if (cnt == plen[ph]) begin
            ph++; cnt = 0;
            if (ph == 3) begin mode = M_COMP; comp_cyc = 0; end
          end
        end
        M_COMP: if (pu_done && comp_cyc != 0) mode = M_DRAIN; else comp_cyc++;
        M_DRAIN: if (popped == l3) mode = M_FIN;
        M_FIN: begin mode = M_IDLE; finished = 1'b1; end
        default: mode = M_IDLE;
      endcase
      cyc++;
    end
    if (!aborted) begin
      check("job_done",   32'(finished),     32'd1);
      check("writes_left",32'(wq.size()),    32'd0);
      check("drain_left", 32'(dq.size()),    32'd0);
      check("words_left", 32'(words.size()), 32'd0);
    end
    s_valid = 1'b0; m_ready = 1'b0; pu_done = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_checks("held");
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset = 1'b0; cfg_start = 1'b0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; pu_done = 1'b0; glb_rdata = '0;
    scramble_cfg();
    model_clear();
    #2;
    reset_checks("reset");
    release_reset();

    run_job(20'h00100, 20'h00200, 20'h00300, 20'h00400, 3, 2, 1, 0, 100, 100, 10, 1'b1, -1);
    run_job(20'h00500, 20'h0, 20'h0, 20'h0, 8, 0, 0, 0, 50, 100, 3, 1'b0, -1);
    run_job(20'h0, 20'h0, 20'h0, 20'h00400, 0, 0, 0, 4, 100, 100, 2, 1'b0, -1);
    run_job(20'h0, 20'h0, 20'h0, 20'h00400, 0, 0, 0, 4, 100, -1, 2, 1'b0, -1);
    run_job(20'hFFFFE, 20'h0, 20'h0, 20'h0, 3, 0, 0, 0, 100, 100, 2, 1'b1, -1);

    run_job(20'h00600, 20'h00700, 20'h00800, 20'h00900, 2, 3, 1, 2, 100, 100, 4, 1'b0, 1);
    release_reset();
    run_job(20'h00610, 20'h00710, 20'h00810, 20'h00910, 2, 3, 1, 2, 70, 70, 3, 1'b0, -1);

    for (int j = 0; j < 8; j++) begin
      run_job(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
              $urandom_range(6), $urandom_range(6), $urandom_range(6), $urandom_range(6),
              $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(6, 1), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
